// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches into a DEPTH-entry FIFO ahead of decode.
// Optional same-cycle empty-queue bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_ce,
    input  logic            i_valid_i,
    input  logic [XLEN-1:0] i_data_in_i,
    output logic [XLEN-1:0] o_addr_i,
    output logic            o_rd_i,
    input  logic            i_br_en,
    input  logic [XLEN-1:0] i_br_addr,
    input  logic            i_id_ready,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_ir,
    output logic [XLEN-1:0] o_id_ret
);

    localparam int              PW  = $clog2(DEPTH);
    localparam int              CW  = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [XLEN-1:0] ir_mem [DEPTH];

    logic rd_en;
    logic br_take;
    logic push;
    logic pop;
    logic head_valid;
    logic bypass;
    logic write_en;
    logic br_addr_unused;

    assign br_addr_unused = ^i_br_addr[1:0];

    // A branch overrides both push and pop; a word returning in that cycle is dropped.
    always_comb begin
        rd_en      = (state == ST_RUN) && (count != FULL);
        br_take    = i_br_en && i_clk_ce;
        push       = rd_en && i_valid_i && i_clk_ce && !i_br_en;
        head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass     = push && (count == '0);
`else
        bypass     = 1'b0;
`endif
        pop        = head_valid && i_id_ready && i_clk_ce && !i_br_en;
        write_en   = push && !(bypass && i_id_ready);
    end

    always_comb begin
        state_next = state;
        if (br_take) begin
            state_next = ST_REDIRECT;
        end else if (i_clk_ce) begin
            case (state)
                ST_RESET:    state_next = ST_RUN;
                ST_RUN:      state_next = ST_RUN;
                ST_REDIRECT: state_next = ST_RUN;
                default:     state_next = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_RESET;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (br_take) begin
                fetch_pc <= {i_br_addr[XLEN-1:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (write_en) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({write_en, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge i_clk) begin
        if (write_en && !i_rst) begin
            pc_mem[wr_ptr] <= fetch_pc;
            ir_mem[wr_ptr] <= i_data_in_i;
        end
    end

    always_comb begin
        o_addr_i   = fetch_pc;
        o_rd_i     = rd_en;
        o_id_valid = head_valid || bypass;
        o_id_pc    = '0;
        o_id_ir    = NOP;
        if (head_valid) begin
            o_id_pc = pc_mem[rd_ptr];
            o_id_ir = ir_mem[rd_ptr];
        end else if (bypass) begin
            o_id_pc = fetch_pc;
            o_id_ir = i_data_in_i;
        end
        o_id_ret = o_id_pc + XLEN'(4);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based behavioural model.
// Honours FETCH_BYPASS_EN in the model when the design is built with it.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_clk_ce;
    logic        i_valid_i;
    logic [31:0] i_data_in_i;
    logic [31:0] o_addr_i;
    logic        o_rd_i;
    logic        i_br_en;
    logic [31:0] i_br_addr;
    logic        i_id_ready;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_ir;
    logic [31:0] o_id_ret;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_ce    (i_clk_ce),
        .i_valid_i   (i_valid_i),
        .i_data_in_i (i_data_in_i),
        .o_addr_i    (o_addr_i),
        .o_rd_i      (o_rd_i),
        .i_br_en     (i_br_en),
        .i_br_addr   (i_br_addr),
        .i_id_ready  (i_id_ready),
        .o_id_valid  (o_id_valid),
        .o_id_pc     (o_id_pc),
        .o_id_ir     (o_id_ir),
        .o_id_ret    (o_id_ret)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    // Model: 0 = held after reset, 1 = fetching, 2 = one-cycle redirect bubble.
    int          mPhase;
    logic [31:0] mPc;
    entry_t      mQ[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ce, input logic valid,
                                 input logic br, input logic ready, input logic [31:0] braddr);
        i_rst       = rst;
        i_clk_ce    = ce;
        i_valid_i   = valid;
        i_data_in_i = memWord(mPc);
        i_br_en     = br;
        i_br_addr   = braddr;
        i_id_ready  = ready;
    endtask

    function automatic bit modelBypass(input bit expRd);
`ifdef FETCH_BYPASS_EN
        return expRd && i_valid_i && i_clk_ce && !i_br_en && (mQ.size() == 0);
`else
        return expRd && 1'b0;
`endif
    endfunction

    task automatic checkAll();
        bit          expRd;
        bit          byp;
        logic [31:0] expPc;
        logic [31:0] expIr;
        expRd = (mPhase == 1) && (mQ.size() != DEPTH);
        byp   = modelBypass(expRd);
        expPc = 32'h0;
        expIr = NOP;
        if (mQ.size() != 0) begin
            expPc = mQ[0].pc;
            expIr = mQ[0].ir;
        end else if (byp) begin
            expPc = mPc;
            expIr = i_data_in_i;
        end
        checkOutput("rd_i",     {31'b0, o_rd_i},     {31'b0, expRd});
        checkOutput("addr_i",   o_addr_i,            mPc);
        checkOutput("id_valid", {31'b0, o_id_valid}, {31'b0, (mQ.size() != 0) || byp});
        checkOutput("id_pc",    o_id_pc,             expPc);
        checkOutput("id_ir",    o_id_ir,             expIr);
        checkOutput("id_ret",   o_id_ret,            expPc + 32'd4);
    endtask

    task automatic advanceModel();
        bit expRd;
        bit byp;
        bit push;
        expRd = (mPhase == 1) && (mQ.size() != DEPTH);
        byp   = modelBypass(expRd);
        if (i_rst) begin
            mPhase = 0;
            mPc    = RESET_PC;
            mQ.delete();
        end else if (i_clk_ce) begin
            if (i_br_en) begin
                mQ.delete();
                mPc    = i_br_addr & 32'hFFFF_FFFC;
                mPhase = 2;
            end else begin
                push = expRd && i_valid_i;
                if (byp && i_id_ready) begin
                    mPc = mPc + 32'd4;
                end else begin
                    if (mQ.size() != 0 && i_id_ready) void'(mQ.pop_front());
                    if (push) begin
                        mQ.push_back('{pc: mPc, ir: i_data_in_i});
                        mPc = mPc + 32'd4;
                    end
                end
                mPhase = 1;
            end
        end
    endtask

    function automatic logic roll(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic doCycles(input int n, input int pv, input int pr, input int pce,
                            input int pbr, input int prst);
        for (int i = 0; i < n; i++) begin
            applyStimulus(roll(prst), roll(pce), roll(pv), roll(pbr), roll(pr),
                          32'($urandom_range(4095, 0)));
            @(negedge i_clk);
            checkAll();
            advanceModel();
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic doBranch(input logic [31:0] target);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, target);
        @(negedge i_clk);
        checkAll();
        advanceModel();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        mPhase = 0;
        mPc    = RESET_PC;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge i_clk);
        #1;
        // Reset hold, stream, fill, drain, half-rate memory, clock-enable stalls.
        doCycles(3,   0,   0,   100, 0, 100);
        doCycles(40,  100, 100, 100, 0, 0);
        doCycles(12,  100, 0,   100, 0, 0);
        doCycles(20,  100, 100, 100, 0, 0);
        doCycles(30,  50,  100, 100, 0, 0);
        doCycles(30,  100, 100, 60,  0, 0);
        // Branch into a full queue with a misaligned target.
        doCycles(8,   100, 0,   100, 0, 0);
        doBranch(32'h0000_0103);
        doCycles(10,  100, 100, 100, 0, 0);
        // Reset with entries queued.
        doCycles(4,   100, 0,   100, 0, 0);
        doCycles(1,   100, 0,   100, 0, 100);
        doCycles(6,   100, 100, 100, 0, 0);
        // Branch during reset hold and during redirect.
        doCycles(1,   100, 100, 100, 0,   100);
        doCycles(3,   100, 100, 100, 100, 0);
        doCycles(2000, 70, 50,  85,  5,   1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
